// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone B4 pipelined initiator: one command in, one Wishbone
// cycle out (with stall, err/ack/rty and timeout handling), one response back.
module wb_cmd_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter int RETRY_MAX  = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  output logic                  busy_o,

  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [3:0]            cmd_sel_i,
  input  logic [31:0]           cmd_dat_i,

  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_dat_o,
  output logic [1:0]            rsp_status_o,

  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic [31:0]           wb_dat_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i,
  input  logic                  wb_stall_i,
  input  logic [31:0]           wb_dat_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_RTY = 2'b10;
  localparam logic [1:0] ST_TMO = 2'b11;

  localparam logic [16:0] TMO_LIMIT   = 17'(TIMEOUT);
  localparam logic [15:0] RETRY_LIMIT = 16'(RETRY_MAX);

  state_t      state;
  logic [15:0] tmo_cnt;
  logic [15:0] retry_cnt;
  logic [16:0] tmo_inc;

  logic        term_hit;
  logic        do_retry;
  logic [1:0]  term_status;
  logic [31:0] term_dat;

  assign cmd_ready_o = (state == S_IDLE);
  assign busy_o      = (state != S_IDLE);

  // tmo_inc is the number of REQ/WAIT cycles including the current one.
  assign tmo_inc = {1'b0, tmo_cnt} + 17'd1;

  // Termination decode; only meaningful while in REQ or WAIT.
  always_comb begin
    term_hit    = 1'b1;
    do_retry    = 1'b0;
    term_status = ST_OK;
    term_dat    = '0;
    if (wb_err_i) begin
      term_status = ST_ERR;
    end else if (wb_ack_i) begin
      term_status = ST_OK;
      term_dat    = wb_we_o ? 32'd0 : wb_dat_i;
    end else if (wb_rty_i) begin
      if (retry_cnt != RETRY_LIMIT) begin
        do_retry = 1'b1;
        term_hit = 1'b0;
      end else begin
        term_status = ST_RTY;
      end
    end else if (tmo_inc == TMO_LIMIT) begin
      term_status = ST_TMO;
    end else begin
      term_hit = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= S_IDLE;
      tmo_cnt      <= '0;
      retry_cnt    <= '0;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_adr_o     <= '0;
      wb_sel_o     <= '0;
      wb_dat_o     <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_dat_o    <= '0;
      rsp_status_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            wb_adr_o  <= cmd_adr_i;
            wb_sel_o  <= cmd_sel_i;
            wb_we_o   <= cmd_we_i;
            wb_dat_o  <= cmd_dat_i;
            wb_cyc_o  <= 1'b1;
            wb_stb_o  <= 1'b1;
            retry_cnt <= '0;
            tmo_cnt   <= '0;
            state     <= S_REQ;
          end
        end
        S_REQ, S_WAIT: begin
          tmo_cnt <= tmo_inc[15:0];
          if (term_hit) begin
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            rsp_valid_o  <= 1'b1;
            rsp_status_o <= term_status;
            rsp_dat_o    <= term_dat;
            state        <= S_RESP;
          end else if (do_retry) begin
            // cyc stays high across the re-issue so the slave sees one bus cycle
            retry_cnt <= retry_cnt + 16'd1;
            tmo_cnt   <= '0;
            wb_stb_o  <= 1'b1;
            state     <= S_REQ;
          end else if ((state == S_REQ) && !wb_stall_i) begin
            wb_stb_o <= 1'b0;
            state    <= S_WAIT;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master (TIMEOUT = 8, RETRY_MAX = 2) with a small
// scripted Wishbone slave.
module tb_wb_cmd_master;

  localparam int K_NONE   = 0;
  localparam int K_ACK    = 1;
  localparam int K_ERR    = 2;
  localparam int K_RTY    = 3;
  localparam int K_ERRACK = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [3:0]  cmd_sel = '0;
  logic [31:0] cmd_dat = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_out;
  logic        wb_ack = 1'b0, wb_err = 1'b0, wb_rty = 1'b0, wb_stall = 1'b0;
  logic [31:0] wb_dat_in = '0;

  int errors = 0;
  int checks = 0;
  int kinds[4];

  wb_cmd_master #(.ADDR_WIDTH(32), .TIMEOUT(8), .RETRY_MAX(2)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .busy_o(busy),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_sel_i(cmd_sel), .cmd_dat_i(cmd_dat),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_status_o(rsp_status),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
    .wb_sel_o(wb_sel), .wb_dat_o(wb_dat_out), .wb_ack_i(wb_ack), .wb_err_i(wb_err),
    .wb_rty_i(wb_rty), .wb_stall_i(wb_stall), .wb_dat_i(wb_dat_in)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one command for a single edge and checks the registered Wishbone request.
  task automatic drive_cmd(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, input string name);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_sel = sel; cmd_dat = dat;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL %s cmd_ready before accept: got %b want 1", name, cmd_ready);
    end
    step();
    cmd_valid = 1'b0;
    checks++;
    if ({wb_cyc, wb_stb, wb_we, busy, cmd_ready} !== {1'b1, 1'b1, we, 1'b1, 1'b0} ||
        wb_adr !== adr || wb_sel !== sel || wb_dat_out !== dat) begin
      errors++;
      $display("FAIL %s request: cyc/stb/we/busy/rdy=%b%b%b%b%b adr=%h sel=%h dat=%h want 11%b10 adr=%h sel=%h dat=%h",
               name, wb_cyc, wb_stb, wb_we, busy, cmd_ready, wb_adr, wb_sel, wb_dat_out, we, adr, sel, dat);
    end
  endtask

  // Scripted slave: stalls each strobe 'stalls' cycles, answers 'lat' cycles after the
  // strobe is accepted with kinds[attempt]. Returns when cyc drops or the budget expires.
  task automatic slave_run(input int stalls, input int lat, input int max_cyc,
                           output int stb_cnt, output int cyc_cnt);
    int st = 0;
    int cd = 0;
    int attempt = 0;
    bit pending = 0;
    stb_cnt = 0;
    cyc_cnt = 0;
    for (int c = 0; c < max_cyc; c++) begin
      if (!wb_cyc) break;
      cyc_cnt++;
      wb_ack = 0; wb_err = 0; wb_rty = 0; wb_stall = 0;
      if (wb_stb) begin
        stb_cnt++;
        if (st < stalls) begin
          wb_stall = 1; st++;
        end else begin
          st = 0; pending = 1; cd = lat;
        end
      end
      if (pending) begin
        if (cd == 0) begin
          case (kinds[attempt])
            K_ACK:    wb_ack = 1;
            K_ERR:    wb_err = 1;
            K_RTY:    wb_rty = 1;
            K_ERRACK: begin wb_err = 1; wb_ack = 1; end
            default: ;
          endcase
          pending = 0;
          if (attempt < 3) attempt++;
        end else begin
          cd--;
        end
      end
      step();
    end
    wb_ack = 0; wb_err = 0; wb_rty = 0; wb_stall = 0;
  endtask

  // Holds rsp_ready low for 'hold' cycles checking the response is stable, then handshakes.
  task automatic handshake_rsp(input int hold, input logic [31:0] exp_dat,
                               input logic [1:0] exp_status, input string name);
    for (int i = 0; i <= hold; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_dat !== exp_dat || rsp_status !== exp_status ||
          cmd_ready !== 1'b0 || wb_cyc !== 1'b0) begin
        errors++;
        $display("FAIL %s rsp[%0d]: valid=%b dat=%h status=%b rdy=%b cyc=%b want 1 %h %b 0 0",
                 name, i, rsp_valid, rsp_dat, rsp_status, cmd_ready, wb_cyc, exp_dat, exp_status);
      end
      if (i < hold) step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after handshake: valid=%b rdy=%b busy=%b want 0 1 0", name, rsp_valid, cmd_ready, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({wb_cyc, wb_stb, wb_we, rsp_valid, busy, cmd_ready} !== 6'b000001 ||
        wb_adr !== 32'd0 || wb_sel !== 4'd0 || wb_dat_out !== 32'd0 ||
        rsp_dat !== 32'd0 || rsp_status !== 2'd0) begin
      errors++;
      $display("FAIL reset: ctl=%b adr=%h sel=%h dat=%h rdat=%h st=%b want 000001 and zeros",
               {wb_cyc, wb_stb, wb_we, rsp_valid, busy, cmd_ready}, wb_adr, wb_sel, wb_dat_out, rsp_dat, rsp_status);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write_stall();
    int sc, cc;
    kinds = '{K_ACK, K_NONE, K_NONE, K_NONE};
    drive_cmd(1'b1, 32'h4, 4'hF, 32'h0000_0123, "write_stall");
    slave_run(2, 1, 40, sc, cc);
    checks++;
    if (sc !== 3 || cc !== 4) begin
      errors++; $display("FAIL write_stall cycles: stb=%0d cyc=%0d want 3 4", sc, cc);
    end
    handshake_rsp(0, 32'd0, 2'b00, "write_stall");
  endtask

  task automatic test_read_hold();
    int sc, cc;
    kinds = '{K_ACK, K_NONE, K_NONE, K_NONE};
    wb_dat_in = 32'hDEAD_BEEF;
    drive_cmd(1'b0, 32'h0, 4'hF, 32'h0, "read_hold");
    slave_run(0, 1, 40, sc, cc);
    checks++;
    if (sc !== 1 || cc !== 2) begin
      errors++; $display("FAIL read_hold cycles: stb=%0d cyc=%0d want 1 2", sc, cc);
    end
    // Stray ack and new bus data while the response waits must not disturb it.
    wb_dat_in = 32'h1111_2222;
    wb_ack = 1'b1;
    handshake_rsp(3, 32'hDEAD_BEEF, 2'b00, "read_hold");
    wb_ack = 1'b0;
  endtask

  task automatic test_retry();
    int sc, cc;
    kinds = '{K_RTY, K_RTY, K_RTY, K_NONE};
    wb_dat_in = 32'hCAFE_0001;
    drive_cmd(1'b0, 32'h10, 4'h3, 32'h0, "retry_exhaust");
    slave_run(0, 1, 40, sc, cc);
    checks++;
    if (sc !== 3 || cc !== 6) begin
      errors++; $display("FAIL retry_exhaust cycles: stb=%0d cyc=%0d want 3 6", sc, cc);
    end
    handshake_rsp(0, 32'd0, 2'b10, "retry_exhaust");

    kinds = '{K_RTY, K_ACK, K_NONE, K_NONE};
    wb_dat_in = 32'h0000_A5A5;
    drive_cmd(1'b0, 32'h14, 4'hF, 32'h0, "retry_ack");
    slave_run(0, 1, 40, sc, cc);
    checks++;
    if (sc !== 2 || cc !== 4) begin
      errors++; $display("FAIL retry_ack cycles: stb=%0d cyc=%0d want 2 4", sc, cc);
    end
    handshake_rsp(0, 32'h0000_A5A5, 2'b00, "retry_ack");
  endtask

  task automatic test_timeout();
    int sc, cc;
    kinds = '{K_NONE, K_NONE, K_NONE, K_NONE};
    drive_cmd(1'b0, 32'h20, 4'hF, 32'h0, "timeout");
    slave_run(0, 1, 40, sc, cc);
    checks++;
    if (sc !== 1 || cc !== 8) begin
      errors++; $display("FAIL timeout cycles: stb=%0d cyc=%0d want 1 8", sc, cc);
    end
    handshake_rsp(0, 32'd0, 2'b11, "timeout");

    kinds = '{K_ACK, K_NONE, K_NONE, K_NONE};
    wb_dat_in = 32'h1234_5678;
    drive_cmd(1'b0, 32'h24, 4'hF, 32'h0, "ack_at_timeout");
    slave_run(0, 7, 40, sc, cc);
    checks++;
    if (sc !== 1 || cc !== 8) begin
      errors++; $display("FAIL ack_at_timeout cycles: stb=%0d cyc=%0d want 1 8", sc, cc);
    end
    handshake_rsp(0, 32'h1234_5678, 2'b00, "ack_at_timeout");
  endtask

  task automatic test_err_and_spurious();
    int sc, cc;
    kinds = '{K_ERRACK, K_NONE, K_NONE, K_NONE};
    wb_dat_in = 32'h5555_5555;
    drive_cmd(1'b0, 32'h30, 4'hF, 32'h0, "err_ack");
    slave_run(0, 1, 40, sc, cc);
    checks++;
    if (sc !== 1 || cc !== 2) begin
      errors++; $display("FAIL err_ack cycles: stb=%0d cyc=%0d want 1 2", sc, cc);
    end
    handshake_rsp(0, 32'd0, 2'b01, "err_ack");

    wb_ack = 1'b1; wb_err = 1'b1; wb_rty = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (rsp_valid !== 1'b0 || wb_cyc !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL spurious[%0d]: valid=%b cyc=%b busy=%b rdy=%b want 0 0 0 1", i, rsp_valid, wb_cyc, busy, cmd_ready);
      end
    end
    wb_ack = 1'b0; wb_err = 1'b0; wb_rty = 1'b0;
  endtask

  task automatic test_back_to_back();
    int sc, cc;
    kinds = '{K_ACK, K_NONE, K_NONE, K_NONE};
    for (int i = 0; i < 2; i++) begin
      drive_cmd(1'b1, 32'h40 + 32'(i * 4), 4'h1, 32'hA0 + 32'(i), "back_to_back");
      slave_run(0, 1, 40, sc, cc);
      checks++;
      if (sc !== 1 || cc !== 2) begin
        errors++; $display("FAIL back_to_back[%0d] cycles: stb=%0d cyc=%0d want 1 2", i, sc, cc);
      end
      handshake_rsp(0, 32'd0, 2'b00, "back_to_back");
    end
  endtask

  task automatic test_reset_mid();
    int sc, cc;
    drive_cmd(1'b0, 32'h50, 4'hF, 32'h0, "reset_mid");
    step();
    step();
    checks++;
    if (busy !== 1'b1 || wb_cyc !== 1'b1 || wb_stb !== 1'b0) begin
      errors++; $display("FAIL reset_mid in WAIT: busy=%b cyc=%b stb=%b want 1 1 0", busy, wb_cyc, wb_stb);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({wb_cyc, wb_stb, wb_we, rsp_valid, busy, cmd_ready} !== 6'b000001 ||
        wb_adr !== 32'd0 || wb_sel !== 4'd0 || rsp_status !== 2'd0 || rsp_dat !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid async: ctl=%b adr=%h sel=%h st=%b rdat=%h want 000001 and zeros",
               {wb_cyc, wb_stb, wb_we, rsp_valid, busy, cmd_ready}, wb_adr, wb_sel, rsp_status, rsp_dat);
    end
    step();
    rst_n = 1'b1;
    step();
    kinds = '{K_ACK, K_NONE, K_NONE, K_NONE};
    drive_cmd(1'b1, 32'h54, 4'hC, 32'h0BAD_F00D, "after_reset");
    slave_run(0, 1, 40, sc, cc);
    checks++;
    if (sc !== 1 || cc !== 2) begin
      errors++; $display("FAIL after_reset cycles: stb=%0d cyc=%0d want 1 2", sc, cc);
    end
    handshake_rsp(0, 32'd0, 2'b00, "after_reset");
  endtask

  initial begin
    test_reset();
    test_write_stall();
    test_read_hold();
    test_retry();
    test_timeout();
    test_err_and_spurious();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
